fifo_write_arbiter: RTL and testbench

- Shares the single write port of the asynchronous FIFO between NUM_REQ producers in the write clock domain.
- Arbitration is round-robin with a bounded burst per grant.
- Drives the FIFO's w_enable and wdata and honours the FIFO's full flag as backpressure.
- A producer holds its word stable until it sees ack; ack marks the cycle in which the word enters the FIFO.

---
 rtl/fifo_arb_pkg.sv | 31 +++
 rtl/fifo_write_arbiter_picker.sv | 25 ++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// The search function is written for up to 16 requesters so RTL and bench can share it.
package fifo_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Returns the first requester after `last` (wrapping modulo num_req), or -1 if none.
    function automatic int next_rr_index(input logic [MAX_REQ-1:0] req,
                                         input int last,
                                         input int num_req);
        int idx;
        int cand;
        idx = -1;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num_req && idx < 0) begin
                cand = last + k;
                if (cand >= num_req)
                    cand = cand - num_req;
                if (req[cand[3:0]])
                    idx = cand;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin picker: first set request bit after the last released owner.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] last,
    output logic                 valid,
    output logic [REQ_IDX_W-1:0] pick
);

    logic [MAX_REQ-1:0] req_ext;
    int                 idx;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        idx                    = next_rr_index(req_ext, int'(last), NUM_REQ);
        valid                  = (idx >= 0);
        pick                   = valid ? REQ_IDX_W'(idx) : '0;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers,
// with a bounded burst per grant and the FIFO full flag as backpressure.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int BITSIZE   = 8,
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2,
    parameter int MAX_BURST = 4,
    parameter int BURST_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BITSIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]           ack,
    input  logic                         full,
    output logic                         w_enable,
    output logic [BITSIZE-1:0]           wdata,
    output logic                         busy,
    output logic [REQ_IDX_W-1:0]         owner
);

    arb_state_t             state, state_nxt;
    logic [REQ_IDX_W-1:0]   owner_q, owner_nxt;
    logic [REQ_IDX_W-1:0]   last_q, last_nxt;
    logic [BURST_W-1:0]     burst_cnt, burst_nxt;
    logic                   pick_vld;
    logic [REQ_IDX_W-1:0]   pick;
    logic                   owner_req;
    logic [BITSIZE-1:0]     owner_data;
    logic                   xfer;
    logic                   burst_done;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .valid (pick_vld),
        .pick  (pick)
    );

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == REQ_IDX_W'(i)) begin
                owner_req  = req[i];
                owner_data = req_data[i*BITSIZE +: BITSIZE];
            end
        end
    end

    // A word moves only in GRANT; reset suppresses the write in the cycle it is sampled.
    assign xfer       = (state == ARB_GRANT) && owner_req && !full && !reset;
    assign burst_done = (burst_cnt == BURST_W'(MAX_BURST - 1));

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++)
            ack[i] = xfer && (owner_q == REQ_IDX_W'(i));
    end

    assign w_enable = |ack;
    assign wdata    = (state == ARB_GRANT) ? owner_data : '0;
    assign busy     = (state == ARB_GRANT);
    assign owner    = owner_q;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        last_nxt  = last_q;
        burst_nxt = burst_cnt;
        unique case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ARB_GRANT;
                    owner_nxt = pick;
                    burst_nxt = '0;
                end
            end
            ARB_GRANT: begin
                // Exhausted burst and producer withdrawal collapse into one release.
                if (!owner_req || (xfer && burst_done)) begin
                    state_nxt = ARB_IDLE;
                    last_nxt  = owner_q;
                    owner_nxt = '0;
                    burst_nxt = '0;
                end else if (xfer) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner_q   <= '0;
            last_q    <= REQ_IDX_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner_q   <= owner_nxt;
            last_q    <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus fairness and burst-limit sequences.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;

    logic [3:0]  ack4, ack1;
    logic        wen4, wen1;
    logic [7:0]  wdata4, wdata1;
    logic        busy4, busy1;
    logic [1:0]  owner4, owner1;

    int total = 0;
    int bad   = 0;

    fifo_write_arbiter #(
        .BITSIZE(8), .NUM_REQ(4), .REQ_IDX_W(2), .MAX_BURST(4), .BURST_W(3)
    ) dut4 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack4),
        .full(full), .w_enable(wen4), .wdata(wdata4), .busy(busy4), .owner(owner4)
    );

    fifo_write_arbiter #(
        .BITSIZE(8), .NUM_REQ(4), .REQ_IDX_W(2), .MAX_BURST(1), .BURST_W(1)
    ) dut1 (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack1),
        .full(full), .w_enable(wen1), .wdata(wdata1), .busy(busy1), .owner(owner1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic [3:0]  ack;
        logic        wen;
        logic [7:0]  wdata;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    localparam int NVEC = 31;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [31:0] d,
                                input logic f, input logic [3:0] a, input logic w,
                                input logic [7:0] wd, input logic b, input logic [1:0] o);
        vec_t v;
        v.rst = rst; v.req = rq; v.data = d; v.full = f;
        v.ack = a; v.wen = w; v.wdata = wd; v.busy = b; v.owner = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Drive from just after a rising edge, settle, then sample mid-cycle.
    task automatic drive(input logic rst, input logic [3:0] rq, input logic [31:0] d, input logic f);
        reset = rst; req = rq; req_data = d; full = f;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
    endtask

    int run_owner;
    int run_len;
    int exp_own;

    initial begin
        reset = 1'b1; req = '0; req_data = '0; full = 1'b0;

        chk("fn_wrap3to1", 32'(next_rr_index(16'h000A, 3, 4)), 32'd1);
        chk("fn_nonpow2",  32'(next_rr_index(16'h0001, 4, 5)), 32'd0);
        chk("fn_skipself", 32'(next_rr_index(16'h0003, 0, 4)), 32'd1);
        chk("fn_none",     32'(next_rr_index(16'h0000, 2, 4)), 32'hFFFF_FFFF);

        // single producer
        tbl[0]  = mk(0, 4'h1, 32'h0000_00A1, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[1]  = mk(0, 4'h1, 32'h0000_00A1, 0, 4'h1, 1, 8'hA1, 1, 2'd0);
        tbl[2]  = mk(0, 4'h1, 32'h0000_00A2, 0, 4'h1, 1, 8'hA2, 1, 2'd0);
        tbl[3]  = mk(0, 4'h1, 32'h0000_00A3, 0, 4'h1, 1, 8'hA3, 1, 2'd0);
        tbl[4]  = mk(0, 4'h0, 32'h0000_00A3, 0, 4'h0, 0, 8'hA3, 1, 2'd0);
        tbl[5]  = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        // full backpressure on producer 2
        tbl[6]  = mk(0, 4'h4, 32'h00C1_0000, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[7]  = mk(0, 4'h4, 32'h00C1_0000, 0, 4'h4, 1, 8'hC1, 1, 2'd2);
        tbl[8]  = mk(0, 4'h4, 32'h00C2_0000, 1, 4'h0, 0, 8'hC2, 1, 2'd2);
        tbl[9]  = mk(0, 4'h4, 32'h00C2_0000, 1, 4'h0, 0, 8'hC2, 1, 2'd2);
        tbl[10] = mk(0, 4'h4, 32'h00C2_0000, 1, 4'h0, 0, 8'hC2, 1, 2'd2);
        tbl[11] = mk(0, 4'h4, 32'h00C2_0000, 1, 4'h0, 0, 8'hC2, 1, 2'd2);
        tbl[12] = mk(0, 4'h4, 32'h00C2_0000, 1, 4'h0, 0, 8'hC2, 1, 2'd2);
        tbl[13] = mk(0, 4'h4, 32'h00C2_0000, 0, 4'h4, 1, 8'hC2, 1, 2'd2);
        tbl[14] = mk(0, 4'h4, 32'h00C3_0000, 0, 4'h4, 1, 8'hC3, 1, 2'd2);
        tbl[15] = mk(0, 4'h4, 32'h00C4_0000, 0, 4'h4, 1, 8'hC4, 1, 2'd2);
        tbl[16] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        // reset mid-burst from producer 1
        tbl[17] = mk(0, 4'h2, 32'h0000_B100, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[18] = mk(0, 4'h2, 32'h0000_B100, 0, 4'h2, 1, 8'hB1, 1, 2'd1);
        tbl[19] = mk(0, 4'h2, 32'h0000_B200, 0, 4'h2, 1, 8'hB2, 1, 2'd1);
        tbl[20] = mk(1, 4'h2, 32'h0000_B300, 0, 4'h0, 0, 8'hB3, 1, 2'd1);
        tbl[21] = mk(0, 4'hA, 32'hD100_B300, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[22] = mk(0, 4'hA, 32'hD100_B300, 0, 4'h2, 1, 8'hB3, 1, 2'd1);
        // withdrawal, then owner 3 drops and the pick wraps to 0
        tbl[23] = mk(0, 4'h8, 32'hD100_0000, 0, 4'h0, 0, 8'h00, 1, 2'd1);
        tbl[24] = mk(0, 4'h8, 32'hD100_0000, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[25] = mk(0, 4'h9, 32'hD100_00E1, 0, 4'h8, 1, 8'hD1, 1, 2'd3);
        tbl[26] = mk(0, 4'h1, 32'h0000_00E1, 0, 4'h0, 0, 8'h00, 1, 2'd3);
        tbl[27] = mk(0, 4'h1, 32'h0000_00E1, 0, 4'h0, 0, 8'h00, 0, 2'd0);
        tbl[28] = mk(0, 4'h1, 32'h0000_00E1, 0, 4'h1, 1, 8'hE1, 1, 2'd0);
        tbl[29] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 1, 2'd0);
        tbl[30] = mk(0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 8'h00, 0, 2'd0);

        #1;
        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].full);
            chk($sformatf("v%0d_ack", i),   32'(ack4),   32'(tbl[i].ack));
            chk($sformatf("v%0d_wen", i),   32'(wen4),   32'(tbl[i].wen));
            chk($sformatf("v%0d_wdata", i), 32'(wdata4), 32'(tbl[i].wdata));
            chk($sformatf("v%0d_busy", i),  32'(busy4),  32'(tbl[i].busy));
            chk($sformatf("v%0d_owner", i), 32'(owner4), 32'(tbl[i].owner));
            next_cycle();
        end

        // word-level round-robin with MAX_BURST=1
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 4'hF, 32'h4332_2110, 1'b0);
            if (c == 0) begin
                chk("rr_reset_busy",  32'(busy1),  32'd0);
                chk("rr_reset_owner", 32'(owner1), 32'd0);
            end
            if (c % 2 == 0) begin
                chk($sformatf("rr%0d_ack", c),  32'(ack1),  32'h0);
                chk($sformatf("rr%0d_busy", c), 32'(busy1), 32'd0);
            end else begin
                exp_own = (c / 2) % 4;
                chk($sformatf("rr%0d_owner", c), 32'(owner1), 32'(exp_own));
                chk($sformatf("rr%0d_ack", c),   32'(ack1),   32'(1 << exp_own));
                chk($sformatf("rr%0d_wdata", c), 32'(wdata1), 32'(8'h10 + 8'h11 * exp_own));
            end
            next_cycle();
        end

        // burst limit of 4 between producers 0 and 1
        do_reset();
        run_owner = -1;
        run_len   = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 4'h3, 32'h0000_2110, 1'b0);
            if (c % 5 == 0) begin
                chk($sformatf("bl%0d_ack", c),  32'(ack4),  32'h0);
                chk($sformatf("bl%0d_busy", c), 32'(busy4), 32'd0);
            end else begin
                exp_own = (c / 5) % 2;
                chk($sformatf("bl%0d_ack", c),   32'(ack4),   32'(1 << exp_own));
                chk($sformatf("bl%0d_owner", c), 32'(owner4), 32'(exp_own));
            end
            if (ack4 != 4'h0) begin
                if (int'(owner4) == run_owner) run_len++;
                else begin run_owner = int'(owner4); run_len = 1; end
                chk($sformatf("bl%0d_run_le4", c), 32'(run_len <= 4), 32'd1);
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
